// File: rtl/sp_ram_core.sv
// sp_ram_core: single-port synchronous RAM, DEPTH x DATA_WIDTH.
// One shared address for read and write. Writes land on the rising edge;
// the read port is registered and read-first, so a same-address write
// returns the old word and the new word appears on the next read.
// rst_n clears only the output register and blocks writes; the array
// itself is never reset so it can map onto a block-RAM primitive.
module sp_ram_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] q
);

  // Storage array; contents are undefined until written.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Registered read data and its next-state value.
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_d;

  // Write gate: no array update while reset is held.
  logic                  wr_en;

  assign wr_en = we && rst_n;

  // Array write port; no reset so the tools can keep this as a RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= data;
    end
  end

  // Read-side next state: the word currently stored at addr.
  // Sampled on the same edge as the write, so the old contents win.
  always_comb begin
    rd_d = mem_q[addr];
  end

  // Output register; asynchronous clear, one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign q = rd_q;

endmodule

// File: tb/tb_sp_ram_core.sv
// Directed testbench for sp_ram_core.
// Inputs change on the falling edge; q is checked on the following
// falling edge, i.e. one rising edge after the address was presented.
module tb_sp_ram_core;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [DW-1:0] q;

  int n_tests;
  int n_fail;

  logic [DW-1:0] sweep_w [32];

  sp_ram_core #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (1 << AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .addr (addr),
    .data (data),
    .q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Present one operation and wait for the next falling edge.
  task automatic op(input logic w, input logic [AW-1:0] a,
                    input logic [DW-1:0] d);
    we   = w;
    addr = a;
    data = d;
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    we    = 1'b0;
    addr  = '0;
    data  = '0;
    for (int i = 0; i < 32; i++) sweep_w[i] = 32'h9E37_79B9 * (i + 1) ^ 32'h0055_AA00;

    // Power-on reset
    @(negedge clk);
    @(negedge clk);
    chk("reset_q", q, 32'h0);
    rst_n = 1'b1;

    // Test 1: give addr 5 a known value, then try to overwrite it under reset
    op(1'b1, 10'd5, 32'h1111_2222);
    op(1'b0, 10'd5, 32'h0);
    chk("t1_pre", q, 32'h1111_2222);
    rst_n = 1'b0;
    #1 chk("t1_async", q, 32'h0);
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 10'd5, 32'hDEAD_BEEF);
      chk($sformatf("t1_hold%0d", i), q, 32'h0);
    end
    rst_n = 1'b1;
    op(1'b0, 10'd5, 32'h0);
    chk("t1_nowrite", q, 32'h1111_2222);

    // Test 2: write then read
    op(1'b1, 10'd0, 32'h0000_00FF);
    op(1'b1, 10'd1, 32'h1234_5678);
    op(1'b0, 10'd0, 32'h0);
    chk("t2_a0", q, 32'h0000_00FF);
    op(1'b0, 10'd1, 32'h0);
    chk("t2_a1", q, 32'h1234_5678);

    // Test 3: sweep 0..31 plus top-bit addresses
    for (int i = 0; i < 32; i++) op(1'b1, AW'(i), sweep_w[i]);
    for (int i = 0; i < 32; i++) begin
      op(1'b0, AW'(i), 32'h0);
      chk($sformatf("t3_rd%0d", i), q, sweep_w[i]);
    end
    op(1'b1, 10'd1023, 32'hC0DE_03FF);
    op(1'b1, 10'd512,  32'hB00B_0200);
    op(1'b0, 10'd1023, 32'h0);
    chk("t3_a1023", q, 32'hC0DE_03FF);
    op(1'b0, 10'd512, 32'h0);
    chk("t3_a512", q, 32'hB00B_0200);
    op(1'b0, 10'd0, 32'h0);
    chk("t3_a0_alias", q, sweep_w[0]);
    op(1'b0, 10'd31, 32'h0);
    chk("t3_a31_alias", q, sweep_w[31]);

    // Test 4: read-first collision
    op(1'b1, 10'd7, 32'hAAAA_5555);
    op(1'b1, 10'd7, 32'h0F0F_0F0F);
    chk("t4_old", q, 32'hAAAA_5555);
    op(1'b0, 10'd7, 32'h0);
    chk("t4_new", q, 32'h0F0F_0F0F);

    // Test 5: asynchronous reset pulse in the middle of a read sweep
    op(1'b0, 10'd10, 32'h0);
    chk("t5_rd10", q, sweep_w[10]);
    op(1'b0, 10'd11, 32'h0);
    chk("t5_rd11", q, sweep_w[11]);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("t5_async", q, 32'h0);
    @(negedge clk);
    chk("t5_held", q, 32'h0);
    rst_n = 1'b1;
    op(1'b0, 10'd11, 32'h0);
    chk("t5_rd11_after", q, sweep_w[11]);
    op(1'b0, 10'd12, 32'h0);
    chk("t5_rd12_after", q, sweep_w[12]);

    // Test 6: hold stable address with no writes
    for (int i = 0; i < 10; i++) begin
      op(1'b0, 10'd7, 32'hFFFF_FFFF);
      chk($sformatf("t6_hold%0d", i), q, 32'h0F0F_0F0F);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
